// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and capture FSM state type for the frame-capture block.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;
  localparam int unsigned ADDR_W_DEF   = 19;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } capture_state_t;

  // Bits needed to hold a counter that saturates at max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Recovers pixel coordinates from VGA sync edges; flags active pixels and over-long lines.
module vga_sync_tracker
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic h_sync,
  input  logic v_sync,
  output logic vs_fall_c,
  output logic active_c,
  output logic line_err_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HCW     = cnt_width(H_TOTAL);
  localparam int unsigned VCW     = cnt_width(V_TOTAL);
  localparam int unsigned H_LO    = H_SYNC + H_BACK;
  localparam int unsigned H_HI    = H_LO + H_ACTIVE;
  localparam int unsigned V_LO    = V_SYNC + V_BACK;
  localparam int unsigned V_HI    = V_LO + V_ACTIVE;

  logic           prev_hs;
  logic           prev_vs;
  logic           hs_fall_c;
  logic [HCW-1:0] hcnt;
  logic [HCW-1:0] hcnt_nxt;
  logic [VCW-1:0] vcnt;
  logic [VCW-1:0] vcnt_nxt;

  // Next coordinates; the active window is judged on the post-update values.
  always_comb begin
    hs_fall_c = pix_en & prev_hs & ~h_sync;
    vs_fall_c = pix_en & prev_vs & ~v_sync;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    if (pix_en) begin
      if (hs_fall_c) begin
        hcnt_nxt = '0;
      end else if (hcnt != HCW'(H_TOTAL)) begin
        hcnt_nxt = hcnt + HCW'(1);
      end
      if (vs_fall_c) begin
        vcnt_nxt = '0;
      end else if (hs_fall_c && (vcnt != VCW'(V_TOTAL))) begin
        vcnt_nxt = vcnt + VCW'(1);
      end
    end
    line_err_c = pix_en && (hcnt != HCW'(H_TOTAL)) && (hcnt_nxt == HCW'(H_TOTAL));
    active_c   = pix_en
              && (hcnt_nxt >= HCW'(H_LO)) && (hcnt_nxt < HCW'(H_HI))
              && (vcnt_nxt >= VCW'(V_LO)) && (vcnt_nxt < VCW'(V_HI));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_hs <= 1'b1;
      prev_vs <= 1'b1;
      hcnt    <= '0;
      vcnt    <= '0;
    end else if (pix_en) begin
      prev_hs <= h_sync;
      prev_vs <= v_sync;
      hcnt    <= hcnt_nxt;
      vcnt    <= vcnt_nxt;
    end
  end

endmodule

// File: rtl/vga_frame_capture.sv
// Single-shot VGA frame grabber: arm, wait for vsync, write one frame of active pixels
// to a linear frame-buffer port.
module vga_frame_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic [7:0]        rgb,
  input  logic              arm,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err
);

  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;

  logic vs_fall_c;
  logic active_c;
  logic line_err_c;
  logic last_pix_c;

  capture_state_t    state;
  capture_state_t    state_nxt;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] pix_cnt_nxt;
  logic              busy_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              frame_done_nxt;
  logic              line_err_nxt;
  logic              frame_err_nxt;

  vga_sync_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_sync_tracker (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .vs_fall_c  (vs_fall_c),
    .active_c   (active_c),
    .line_err_c (line_err_c)
  );

  assign last_pix_c = (pix_cnt == ADDR_W'(FRAME_PIX - 1));

  // Next-state and write-port decode; busy lingers one clk after returning to IDLE.
  always_comb begin
    state_nxt      = state;
    pix_cnt_nxt    = pix_cnt;
    busy_nxt       = busy;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    frame_done_nxt = 1'b0;
    line_err_nxt   = line_err | line_err_c;
    frame_err_nxt  = frame_err;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (arm) begin
          state_nxt     = ARMED;
          busy_nxt      = 1'b1;
          pix_cnt_nxt   = '0;
          line_err_nxt  = line_err_c;
          frame_err_nxt = 1'b0;
        end
      end
      ARMED: begin
        if (vs_fall_c) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vs_fall_c) begin
          frame_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end else if (active_c) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = pix_cnt;
          wr_data_nxt = rgb;
          pix_cnt_nxt = pix_cnt + ADDR_W'(1);
          if (last_pix_c) begin
            frame_done_nxt = 1'b1;
            state_nxt      = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pix_cnt    <= pix_cnt_nxt;
      busy       <= busy_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      frame_done <= frame_done_nxt;
      line_err   <= line_err_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

endmodule
